ssd_scan_mux: RTL and testbench

- Parametrised N-digit seven-segment scan multiplexer with its own refresh prescaler, digit counter, snapshot register and per-digit blink.
- Successor to the fixed 4-digit, externally-sequenced scanner.
- Sits between time/counter datapaths (BCD digits) and the BCD-to-segment decoder driving the board's common-anode digit enables.

---
 rtl/ssd_scan_mux.sv | 110 +++++++++++
 tb/tb_ssd_scan_mux.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_mux.sv
// N-digit seven-segment scan multiplexer: refresh prescaler, leftmost-first digit scan,
// snapshot register and per-digit blink. Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module ssd_scan_mux #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [4*DIGITS-1:0]       digits_in,
    input  logic [DIGITS-1:0]         blink_mask,
    output logic [DIGITS-1:0]         ssd_ctl,
    output logic [3:0]                ssd_in,
    output logic [$clog2(DIGITS)-1:0] digit_idx
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int PW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PW-1:0]    PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [IDX_W-1:0] SLOT_LAST  = IDX_W'(DIGITS - 1);

    logic [PW-1:0]         presc_q, presc_d;
    logic [IDX_W-1:0]      slot_q, slot_d;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    logic                  phase_q, phase_d;
    logic [4*DIGITS-1:0]   snap_q, snap_d;
    logic [DIGITS-1:0]     ctl_q, ctl_d;
    logic [3:0]            val_q, val_d;
    logic [IDX_W-1:0]      idx_q;

    logic                  tick;
    logic [IDX_W-1:0]      sel;
    logic [3:0]            sel_val;
    logic                  lz_blank;
    logic                  blank;

    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
        slot_d  = slot_q;
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (tick) begin
            // Explicit compare-and-wrap keeps non-power-of-2 scans out of unused slots.
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
            if (bcnt_q == BLINK_LAST) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
        snap_d = load ? digits_in : snap_q;
    end

    // Slot 0 shows the leftmost digit, so the displayed digit index runs backwards.
    assign sel     = SLOT_LAST - slot_q;
    assign sel_val = snap_q[{sel, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] lead_zero;

    always_comb begin
        lead_zero             = '0;
        lead_zero[DIGITS-1]   = (snap_q[4*DIGITS-1 -: 4] == 4'd0);
        for (int k = DIGITS - 2; k >= 0; k--) begin
            lead_zero[k] = lead_zero[k+1] && (snap_q[4*k +: 4] == 4'd0);
        end
    end

    assign lz_blank = (sel != '0) && lead_zero[sel];
`else
    assign lz_blank = 1'b0;
`endif

    assign blank = (phase_q && blink_mask[sel]) || lz_blank;
    assign ctl_d = blank ? '1 : ~(DIGITS'(1) << sel);
    assign val_d = blank ? 4'd0 : sel_val;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            slot_q  <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            snap_q  <= '0;
            ctl_q   <= '1;
            val_q   <= 4'd0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_d;
            slot_q  <= slot_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            snap_q  <= snap_d;
            ctl_q   <= ctl_d;
            val_q   <= val_d;
            idx_q   <= slot_q;
        end
    end

    assign ssd_ctl   = ctl_q;
    assign ssd_in    = val_q;
    assign digit_idx = idx_q;

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Bench for ssd_scan_mux: a 4-digit and a 6-digit instance checked every cycle against a
// time-based model (slot and blink phase derived from cycles since reset release).
module tb_ssd_scan_mux;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] digits4;
    logic [3:0]  mask4;
    logic [3:0]  ctl4;
    logic [3:0]  in4;
    logic [1:0]  idx4;
    logic [23:0] digits6;
    logic [5:0]  mask6;
    logic [5:0]  ctl6;
    logic [3:0]  in6;
    logic [2:0]  idx6;

    int n_cmp = 0;
    int n_err = 0;

    ssd_scan_mux #(.DIGITS(4), .REFRESH_DIV(4), .BLINK_DIV(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits4), .blink_mask(mask4),
        .ssd_ctl(ctl4), .ssd_in(in4), .digit_idx(idx4)
    );

    ssd_scan_mux #(.DIGITS(6), .REFRESH_DIV(1), .BLINK_DIV(3)) dut6 (
        .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits6), .blink_mask(mask6),
        .ssd_ctl(ctl6), .ssd_in(in6), .digit_idx(idx6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed result: [14:12] slot, [11:8] value, [7:0] active-low enables.
    function automatic logic [14:0] model_out(int d, int r, int b, int unsigned c,
                                              logic [31:0] snap, logic [7:0] mask);
        int       t     = int'(c) / r;
        int       s     = t % d;
        int       k     = d - 1 - s;
        bit       ph    = ((t / b) % 2) == 1;
        logic [3:0] v   = snap[4*k +: 4];
        bit       blank = ph && mask[k];
        logic [7:0] ctl = 8'hFF;
        logic [2:0] sl  = 3'(s);
`ifdef LEADING_ZERO_BLANK_EN
        if (k >= 1) begin
            bit allz = 1'b1;
            for (int j = k; j < d; j++) if (snap[4*j +: 4] != 4'd0) allz = 1'b0;
            if (allz) blank = 1'b1;
        end
`endif
        if (!blank) ctl[k] = 1'b0;
        if (blank) v = 4'd0;
        return {sl, v, ctl};
    endfunction

    int unsigned  cyc;
    logic [15:0]  snap4_m;
    logic [23:0]  snap6_m;
    logic [14:0]  e4, e6;
    logic         vld;

    initial vld = 1'b0;

    always @(posedge clk) begin
        vld <= 1'b1;
        if (!rst_n) begin
            e4      <= {3'd0, 4'd0, 8'hFF};
            e6      <= {3'd0, 4'd0, 8'hFF};
            cyc     <= 0;
            snap4_m <= '0;
            snap6_m <= '0;
        end else begin
            e4  <= model_out(4, 4, 2, cyc, {16'h0, snap4_m}, {4'h0, mask4});
            e6  <= model_out(6, 1, 3, cyc, {8'h0, snap6_m}, {2'h0, mask6});
            cyc <= cyc + 1;
            if (load) begin
                snap4_m <= digits4;
                snap6_m <= digits6;
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (vld) begin
                chk("m4_ctl", 32'(ctl4), 32'(e4[3:0]));
                chk("m4_in",  32'(in4),  32'(e4[11:8]));
                chk("m4_idx", 32'(idx4), 32'(e4[13:12]));
                chk("m6_ctl", 32'(ctl6), 32'(e6[5:0]));
                chk("m6_in",  32'(in6),  32'(e6[11:8]));
                chk("m6_idx", 32'(idx6), 32'(e6[14:12]));
                chk("m4_onelow", 32'($countones(~ctl4) <= 1), 32'd1);
                chk("m6_onelow", 32'($countones(~ctl6) <= 1), 32'd1);
                chk("m6_idx_legal", 32'(idx6 < 3'd6), 32'd1);
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic lit4(string name, logic [3:0] ctl, logic [3:0] val);
        chk({name, "_ctl"}, 32'(ctl4), 32'(ctl));
        chk({name, "_in"},  32'(in4),  32'(val));
    endtask

    initial begin
        rst_n   = 1'b0;
        load    = 1'b0;
        digits4 = '0;
        mask4   = '0;
        digits6 = 24'h907310;
        mask6   = 6'b100101;

        step(3);
        lit4("rst", 4'b1111, 4'd0);
        chk("rst_idx4", 32'(idx4), 32'd0);
        chk("rst_ctl6", 32'(ctl6), 32'h3F);

        rst_n   = 1'b1;
        load    = 1'b1;
        digits4 = 16'h1259;
        step(1);                             // c=0: snapshot still zero here
`ifdef LEADING_ZERO_BLANK_EN
        lit4("first", 4'b1111, 4'd0);
`else
        lit4("first", 4'b0111, 4'd0);
`endif
        load    = 1'b0;
        digits4 = 16'h0000;
        step(1);  lit4("s0", 4'b0111, 4'd1); chk("idx6_c1", 32'(idx6), 32'd1);
        step(3);  lit4("s1", 4'b1011, 4'd2); chk("idx6_c4", 32'(idx6), 32'd4);
        step(4);  lit4("s2", 4'b1101, 4'd5); chk("idx6_c8", 32'(idx6), 32'd2);
        step(4);  lit4("s3", 4'b1110, 4'd9); chk("idx6_c12", 32'(idx6), 32'd0);
        step(4);  lit4("wrap", 4'b0111, 4'd1);

        step(2);                             // load lands on the tick into slot 1
        load = 1'b1; digits4 = 16'h3478;
        step(1);  load = 1'b0;
        step(1);  lit4("collide", 4'b1011, 4'd4);

        load = 1'b1; digits4 = 16'h0050;
        step(1);  load = 1'b0;
        step(1);
`ifdef LEADING_ZERO_BLANK_EN
        lit4("lz_d2", 4'b1111, 4'd0);
`else
        lit4("lz_d2", 4'b1011, 4'd0);
`endif
        step(2);  lit4("lz_d1", 4'b1101, 4'd5);
        load = 1'b1; digits4 = 16'h0000;
        step(1);  load = 1'b0;
        step(3);  lit4("zero_d0", 4'b1110, 4'd0);
        step(4);
`ifdef LEADING_ZERO_BLANK_EN
        lit4("zero_d3", 4'b1111, 4'd0);
`else
        lit4("zero_d3", 4'b0111, 4'd0);
`endif

        load = 1'b1; digits4 = 16'h1259; mask4 = 4'b0011;
        step(1);  load = 1'b0;
        step(11); lit4("blink_off", 4'b1111, 4'd0);
        step(4);  lit4("blink_d3", 4'b0111, 4'd1);
        mask4 = 4'b0000;
        step(8);  lit4("noblink_d1", 4'b1101, 4'd5);
        step(4);  lit4("noblink_d0", 4'b1110, 4'd9);

        rst_n = 1'b0;
        step(2);
        lit4("midrst", 4'b1111, 4'd0);
        chk("midrst_idx6", 32'(idx6), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            load    = ($urandom % 8) == 0;
            digits4 = 16'($urandom);
            digits6 = 24'($urandom);
            if ($urandom % 2) digits4 = digits4 >> (4 * ($urandom % 4));
            if ($urandom % 2) digits6 = digits6 >> (4 * ($urandom % 6));
            if (($urandom % 64) == 0) mask4 = 4'($urandom);
            if (($urandom % 64) == 0) mask6 = 6'($urandom);
            rst_n = ($urandom % 500) != 0;
            step(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
